computer_4bit_loader: RTL and testbench

Boot and run sequencer for `computer_4bit`: accepts a program (instruction + data word per address) from a host over a valid/ready stream and drives the computer's load port while holding it in load mode. It then releases the computer for a programmed number of cycles and captures `d_out`, `ZF` and `CF` into result registers. It sits between the host/test harness and the `computer_4bit` load/run pins, replacing hand-sequenced load loops.

---
 rtl/computer_4bit_pkg.sv | 28 ++
 rtl/computer_4bit_loader_if.sv | 10 +
 rtl/loader_run_counter.sv | 25 ++
 rtl/computer_4bit_loader.sv | 185 ++++++++++++++++++
 tb/tb_computer_4bit_loader.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/computer_4bit_pkg.sv
// rtl/computer_4bit_pkg.sv - shared types and instruction field helpers for the computer_4bit loader
package computer_4bit_pkg;

  localparam logic [3:0] OPC_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_RUN,
    ST_DONE
  } loader_state_t;

  // Instruction byte layout is {address, opcode}
  function automatic logic [3:0] ins_addr(input logic [7:0] ins);
    return ins[7:4];
  endfunction

  function automatic logic [3:0] ins_op(input logic [7:0] ins);
    return ins[3:0];
  endfunction

  // A zero run length still gives the computer one cycle out of load mode
  function automatic logic [7:0] run_len(input logic [7:0] cycles);
    return (cycles == 8'd0) ? 8'd1 : cycles;
  endfunction

endpackage

// File: rtl/computer_4bit_loader_if.sv
// rtl/computer_4bit_loader_if.sv - host program stream (valid/ready) into the loader
interface computer_4bit_loader_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_ins;
  logic [3:0] s_data;

  modport master (output s_valid, output s_ins, output s_data, input  s_ready);
  modport slave  (input  s_valid, input  s_ins, input  s_data, output s_ready);
endinterface

// File: rtl/loader_run_counter.sv
// rtl/loader_run_counter.sv - 8-bit loadable down-counter timing the RUN phase
module loader_run_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] value,
  output logic       last
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 8'd0;
    end else if (load) begin
      count <= value;
    end else if (en && count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign last = (count == 8'd1);

endmodule

// File: rtl/computer_4bit_loader.sv
// rtl/computer_4bit_loader.sv - loads a program into computer_4bit, runs it, captures the result
// Optional HLT presence check enabled by LOADER_HLT_CHECK_EN
module computer_4bit_loader
  import computer_4bit_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(DEPTH):0]     prog_len,
  input  logic [7:0]                 run_cycles,
  computer_4bit_loader_if.slave      s,
  output logic                       cpu_load,
  output logic [$clog2(DEPTH)-1:0]   cpu_addr,
  output logic [7:0]                 cpu_ins,
  output logic [3:0]                 cpu_data,
  input  logic [3:0]                 cpu_dout,
  input  logic                       cpu_zf,
  input  logic                       cpu_cf,
  output logic                       busy,
  output logic                       done,
  output logic [3:0]                 result,
  output logic                       res_zf,
  output logic                       res_cf,
  output logic                       err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  loader_state_t state, state_next;

  logic [AW:0] idx;
  logic [AW:0] words;
  logic [AW:0] len_clamped;
  logic [7:0]  run_len_q;
  logic        ready_c;
  logic        start_ok;
  logic        accept;
  logic        run_load;
  logic        run_en;
  logic        run_last;
  logic        capture;
  logic        reject;
  logic        hlt_missing;
  logic        last_word;

  assign len_clamped = (prog_len > DEPTH_W) ? DEPTH_W : prog_len;
  assign last_word   = (idx == words - 1'b1);
  assign s.s_ready   = ready_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ready_c    = 1'b0;
    cpu_load   = 1'b1;
    busy       = 1'b0;
    start_ok   = 1'b0;
    accept     = 1'b0;
    run_load   = 1'b0;
    run_en     = 1'b0;
    capture    = 1'b0;
    reject     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start && prog_len != '0) begin
          start_ok   = 1'b1;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ready_c = 1'b1;
        busy    = 1'b1;
        accept  = s.s_valid;
        if (accept && last_word) begin
          state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        busy = 1'b1;
        if (hlt_missing) begin
          reject     = 1'b1;
          state_next = ST_DONE;
        end else begin
          run_load   = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy     = 1'b1;
        cpu_load = 1'b0;
        run_en   = 1'b1;
        if (run_last) begin
          capture    = 1'b1;
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Bus holds the last accepted word through stalls and SETTLE so the computer re-samples it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= '0;
      words     <= '0;
      run_len_q <= 8'd0;
      cpu_addr  <= '0;
      cpu_ins   <= 8'd0;
      cpu_data  <= 4'd0;
      done      <= 1'b0;
      result    <= 4'd0;
      res_zf    <= 1'b0;
      res_cf    <= 1'b0;
    end else begin
      if (start_ok) begin
        idx       <= '0;
        words     <= len_clamped;
        run_len_q <= run_len(run_cycles);
        done      <= 1'b0;
      end
      if (accept) begin
        cpu_addr <= idx[AW-1:0];
        cpu_ins  <= s.s_ins;
        cpu_data <= s.s_data;
        idx      <= idx + 1'b1;
      end
      if (capture) begin
        result <= cpu_dout;
        res_zf <= cpu_zf;
        res_cf <= cpu_cf;
        done   <= 1'b1;
      end
      if (reject) begin
        done <= 1'b1;
      end
    end
  end

`ifdef LOADER_HLT_CHECK_EN
  logic hlt_seen;
  logic err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hlt_seen <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (start_ok) begin
        hlt_seen <= 1'b0;
        err_q    <= 1'b0;
      end else if (accept && ins_op(s.s_ins) == OPC_HLT) begin
        hlt_seen <= 1'b1;
      end
      if (reject) begin
        err_q <= 1'b1;
      end
    end
  end

  assign hlt_missing = ~hlt_seen;
  assign err         = err_q;
`else
  assign hlt_missing = 1'b0;
  assign err         = 1'b0;
`endif

  loader_run_counter u_run_counter (
    .clk   (clk),
    .rst   (rst),
    .load  (run_load),
    .en    (run_en),
    .value (run_len_q),
    .last  (run_last)
  );

endmodule

// File: tb/tb_computer_4bit_loader.sv
// tb/tb_computer_4bit_loader.sv - self-checking bench for computer_4bit_loader
module tb_computer_4bit_loader;

  localparam int DEPTH = 16;
`ifdef LOADER_HLT_CHECK_EN
  localparam bit HLT_EN = 1'b1;
`else
  localparam bit HLT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [4:0] prog_len = 5'd0;
  logic [7:0] run_cycles = 8'd0;
  logic       cpu_load;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_ins;
  logic [3:0] cpu_data;
  logic [3:0] cpu_dout;
  logic       cpu_zf, cpu_cf;
  logic       busy, done, res_zf, res_cf, err;
  logic [3:0] result;

  computer_4bit_loader_if s_if ();

  computer_4bit_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .prog_len(prog_len), .run_cycles(run_cycles),
    .s(s_if), .cpu_load(cpu_load), .cpu_addr(cpu_addr), .cpu_ins(cpu_ins), .cpu_data(cpu_data),
    .cpu_dout(cpu_dout), .cpu_zf(cpu_zf), .cpu_cf(cpu_cf), .busy(busy), .done(done),
    .result(result), .res_zf(res_zf), .res_cf(res_cf), .err(err)
  );

  always #5 clk = ~clk;

  // Stub computer: records load-mode writes and counts cycles spent out of load mode
  logic [7:0]  run_cnt = 8'd0;
  logic [3:0]  salt = 4'd0;
  logic [11:0] mem [DEPTH];
  always @(posedge clk) begin
    if (cpu_load) begin
      run_cnt <= 8'd0;
      mem[cpu_addr] <= {cpu_ins, cpu_data};
    end else begin
      run_cnt <= run_cnt + 8'd1;
    end
  end
  assign cpu_dout = run_cnt[3:0] ^ salt;
  assign cpu_zf   = ((run_cnt[3:0] ^ salt) == 4'd0);
  assign cpu_cf   = run_cnt[4];

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] p_ins  [32];
  logic [3:0] p_data [32];
  logic [3:0] last_res = 4'd0;
  logic       last_zf = 1'b0, last_cf = 1'b0;

  typedef struct {
    int plen; int rcyc; int stall_word; int stall_len;
    bit pulse; bit nohlt; bit fixed; int exp_words; int exp_run;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_prog(input bit fixed, input bit nohlt, input int nwords);
    logic [7:0] fx_ins [7];
    logic [3:0] fx_dat [7];
    fx_ins = '{8'h16, 8'h02, 8'h48, 8'h0B, 8'h05, 8'h04, 8'h0F};
    fx_dat = '{4'h0, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    for (int i = 0; i < 32; i++) begin
      p_ins[i]  = {i[3:0], 4'($urandom_range(0, 14))};
      p_data[i] = 4'($urandom);
    end
    if (fixed) begin
      for (int i = 0; i < 7; i++) begin
        p_ins[i]  = fx_ins[i];
        p_data[i] = fx_dat[i];
      end
    end else if (!nohlt) begin
      p_ins[nwords-1][3:0] = 4'hF;
    end
  endtask

  // Drives one load+run sequence from IDLE/DONE and checks it against the expected words/run length
  task automatic run_seq(input string tag, input int plen, input int rcyc, input int stall_word,
                         input int stall_len, input int stall_pct, input bit pulse,
                         input int exp_words, input int exp_run, input bit chk_cycles);
    int k, n, low, guard, stall_left, load_cyc, bad;
    bit hs, stalled, exp_err, v;
    logic [3:0] er;
    exp_err = HLT_EN;
    for (int i = 0; i < exp_words; i++) if (p_ins[i][3:0] == 4'hF) exp_err = 1'b0;
    salt = 4'($urandom);
    start = 1'b1; prog_len = 5'(plen); run_cycles = 8'(rcyc);
    @(posedge clk); #1;
    start = 1'b0; prog_len = 5'($urandom); run_cycles = 8'($urandom);
    check($sformatf("%s busy_after_start", tag), busy, 1);
    check($sformatf("%s ready_after_start", tag), s_if.s_ready, 1);
    check($sformatf("%s done_cleared", tag), done, 0);
    k = 0; guard = 0; stall_left = 0; stalled = 1'b0; load_cyc = 0;
    while (guard < 2000 && s_if.s_ready) begin
      if (k == stall_word && !stalled) begin stall_left = stall_len; stalled = 1'b1; end
      if (stall_left > 0) begin v = 1'b0; stall_left--; end
      else v = ($urandom_range(0, 99) >= stall_pct);
      s_if.s_valid = v; s_if.s_ins = p_ins[k % 32]; s_if.s_data = p_data[k % 32];
      hs = v && s_if.s_ready;
      @(posedge clk); #1;
      load_cyc++; guard++;
      if (hs) begin
        if (cpu_addr !== 4'(k) || cpu_ins !== p_ins[k] || cpu_data !== p_data[k])
          check($sformatf("%s bus_word%0d", tag, k), {cpu_addr, cpu_ins, cpu_data}, {4'(k), p_ins[k], p_data[k]});
        else n_tests++;
        k++;
      end else if (k > 0 && cpu_addr !== 4'(k - 1)) begin
        check($sformatf("%s stall_hold", tag), cpu_addr, 4'(k - 1));
      end
    end
    s_if.s_valid = 1'b0;
    check($sformatf("%s words_accepted", tag), k, exp_words);
    if (chk_cycles) check($sformatf("%s load_cycles", tag), load_cyc, exp_words + stall_len);
    check($sformatf("%s settle_load", tag), cpu_load, 1);
    check($sformatf("%s settle_busy", tag), busy, 1);
    n = 0; low = 0;
    while (!done && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (!cpu_load) low++;
      start = pulse && n == 1 && !done;
      prog_len = 5'd7;
    end
    start = 1'b0;
    check($sformatf("%s done_latency", tag), n, exp_err ? 1 : 1 + exp_run);
    check($sformatf("%s run_cycles_low", tag), low, exp_err ? 0 : exp_run);
    check($sformatf("%s err", tag), err, exp_err);
    check($sformatf("%s busy_end", tag), busy, 0);
    check($sformatf("%s load_end", tag), cpu_load, 1);
    if (!exp_err) begin
      er = 4'(exp_run - 1) ^ salt;
      last_res = er; last_zf = (er == 4'd0); last_cf = 1'((exp_run - 1) >> 4);
    end
    check($sformatf("%s result", tag), {result, res_zf, res_cf}, {last_res, last_zf, last_cf});
    bad = 0;
    for (int i = 0; i < exp_words; i++) if (mem[i] !== {p_ins[i], p_data[i]}) bad++;
    check($sformatf("%s program_image", tag), bad, 0);
    @(posedge clk); #1;
    check($sformatf("%s done_hold", tag), done, 1);
  endtask

  initial begin
    vecs[0] = '{plen:7,  rcyc:20,  stall_word:-1, stall_len:0, pulse:0, nohlt:0, fixed:1, exp_words:7,  exp_run:20};
    vecs[1] = '{plen:7,  rcyc:20,  stall_word:3,  stall_len:3, pulse:0, nohlt:0, fixed:1, exp_words:7,  exp_run:20};
    vecs[2] = '{plen:20, rcyc:3,   stall_word:-1, stall_len:0, pulse:0, nohlt:0, fixed:0, exp_words:16, exp_run:3};
    vecs[3] = '{plen:4,  rcyc:0,   stall_word:-1, stall_len:0, pulse:0, nohlt:0, fixed:0, exp_words:4,  exp_run:1};
    vecs[4] = '{plen:5,  rcyc:10,  stall_word:-1, stall_len:0, pulse:1, nohlt:0, fixed:0, exp_words:5,  exp_run:10};
    vecs[5] = '{plen:3,  rcyc:5,   stall_word:-1, stall_len:0, pulse:0, nohlt:1, fixed:0, exp_words:3,  exp_run:5};
    vecs[6] = '{plen:16, rcyc:255, stall_word:-1, stall_len:0, pulse:0, nohlt:0, fixed:0, exp_words:16, exp_run:255};
    vecs[7] = '{plen:1,  rcyc:1,   stall_word:-1, stall_len:0, pulse:1, nohlt:0, fixed:0, exp_words:1,  exp_run:1};

    s_if.s_valid = 1'b0; s_if.s_ins = 8'd0; s_if.s_data = 4'd0;
    #12;
    check("reset_outputs", {cpu_load, s_if.s_ready, cpu_addr, cpu_ins, cpu_data, busy, done, result, res_zf, res_cf, err},
          {1'b1, 1'b0, 4'd0, 8'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 8; t++) begin
      fill_prog(vecs[t].fixed, vecs[t].nohlt, vecs[t].exp_words);
      run_seq($sformatf("vec%0d", t), vecs[t].plen, vecs[t].rcyc, vecs[t].stall_word, vecs[t].stall_len,
              0, vecs[t].pulse, vecs[t].exp_words, vecs[t].exp_run, 1'b1);
    end

    // prog_len of zero must not leave DONE
    start = 1'b1; prog_len = 5'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("zero_len_busy%0d", i), {busy, s_if.s_ready, done}, {1'b0, 1'b0, 1'b1});
    end
    start = 1'b0;

    // Reset in the middle of LOAD abandons the partial program
    fill_prog(1'b1, 1'b0, 7);
    start = 1'b1; prog_len = 5'd7; run_cycles = 8'd20;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_if.s_valid = 1'b1; s_if.s_ins = p_ins[i]; s_if.s_data = p_data[i];
      @(posedge clk); #1;
    end
    check("mid_load_addr", cpu_addr, 4'd2);
    s_if.s_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("mid_reset_outputs", {cpu_load, s_if.s_ready, cpu_addr, cpu_ins, cpu_data, busy, done, result, res_zf, res_cf, err},
          {1'b1, 1'b0, 4'd0, 8'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1;
    rst = 1'b1;
    last_res = 4'd0; last_zf = 1'b0; last_cf = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset", {busy, s_if.s_ready, cpu_load}, {1'b0, 1'b0, 1'b1});
    run_seq("after_reset", 7, 20, -1, 0, 0, 1'b0, 7, 20, 1'b1);

    // Randomized sequences against the length/latency model
    for (int r = 0; r < 25; r++) begin
      int plen, rcyc;
      plen = $urandom_range(1, 20);
      rcyc = $urandom_range(0, 30);
      for (int i = 0; i < 32; i++) begin
        p_ins[i] = 8'($urandom); p_data[i] = 4'($urandom);
      end
      run_seq($sformatf("rand%0d", r), plen, rcyc, -1, 0, 30, 1'($urandom_range(0, 1)),
              (plen > DEPTH) ? DEPTH : plen, (rcyc == 0) ? 1 : rcyc, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
